// File: rtl/ct_field_router.sv
// Packet router stage: steers each packet to one of N_OUT ports using the first-beat field,
// through a registered main/skid buffer. Optional drop counter under CT_ROUTER_DROP_CNT_EN.
module ct_field_router #(
  parameter int WD    = 32,
  parameter int WF    = 2,
  parameter int N_OUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WD-1:0]    i_data,
  input  logic [WF-1:0]    i_field,
  input  logic             i_eop,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WD-1:0]    o_data,
  output logic             o_eop,
  output logic [N_OUT-1:0] o_valid,
  input  logic [N_OUT-1:0] i_ready
`ifdef CT_ROUTER_DROP_CNT_EN
  ,
  output logic [15:0]      o_drop_count
`endif
);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t        state, state_nx;
  logic [WF-1:0] dest_r, dest_nx, beat_dest;
  logic          accept, in_range, keep, push, out_fire;

  logic          m_valid, m_eop;
  logic [WD-1:0] m_data;
  logic [WF-1:0] m_dest;
  logic          s_valid, s_eop, s_valid_nx, main_free;
  logic [WD-1:0] s_data;
  logic [WF-1:0] s_dest;

  always_comb begin
    accept    = i_valid && o_ready;
    in_range  = {1'b0, i_field} < (WF+1)'(N_OUT);
    state_nx  = state;
    dest_nx   = dest_r;
    keep      = 1'b0;
    beat_dest = dest_r;
    case (state)
      IDLE: begin
        beat_dest = i_field;
        keep      = in_range;
        if (accept) begin
          if (in_range) begin
            dest_nx  = i_field;
            state_nx = i_eop ? IDLE : PKT;
          end else begin
            state_nx = i_eop ? IDLE : DROP;
          end
        end
      end
      PKT: begin
        keep = 1'b1;
        if (accept && i_eop) state_nx = IDLE;
      end
      DROP: begin
        if (accept && i_eop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      dest_r <= '0;
    end else begin
      state  <= state_nx;
      dest_r <= dest_nx;
    end
  end

  always_comb begin
    o_valid = '0;
    for (int unsigned i = 0; i < N_OUT; i++)
      o_valid[i] = m_valid && (m_dest == WF'(i));
  end

  assign o_data    = m_data;
  assign o_eop     = m_eop;
  assign out_fire  = |(o_valid & i_ready);
  assign push      = accept && keep;
  assign main_free = !m_valid || out_fire;
  // Skid only stays/becomes occupied if main cannot take the oldest beat this edge
  assign s_valid_nx = main_free ? (s_valid && push) : (s_valid || push);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_eop   <= 1'b0;
      m_dest  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_eop   <= 1'b0;
      s_dest  <= '0;
      o_ready <= 1'b0;
    end else begin
      s_valid <= s_valid_nx;
      o_ready <= !s_valid_nx;
      if (main_free) begin
        if (s_valid) begin
          m_valid <= 1'b1;
          m_data  <= s_data;
          m_eop   <= s_eop;
          m_dest  <= s_dest;
          if (push) begin
            s_data <= i_data;
            s_eop  <= i_eop;
            s_dest <= beat_dest;
          end
        end else begin
          m_valid <= push;
          if (push) begin
            m_data <= i_data;
            m_eop  <= i_eop;
            m_dest <= beat_dest;
          end
        end
      end else if (push) begin
        s_data <= i_data;
        s_eop  <= i_eop;
        s_dest <= beat_dest;
      end
    end
  end

`ifdef CT_ROUTER_DROP_CNT_EN
  logic        drop_first;
  logic [15:0] drop_cnt;

  always_comb drop_first = accept && (state == IDLE) && !in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      drop_cnt <= '0;
    else if (drop_first && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 16'd1;
  end

  assign o_drop_count = drop_cnt;
`endif

endmodule
